// File: rtl/pci_bus_arbiter_if.sv
// Bus-side signal bundle for the central PCI arbiter.
// The arbiter connects through the master modport; the requesting devices
// (or a testbench standing in for them) use the slave modport.
interface pci_bus_arbiter_if #(
  parameter int N_DEV = 3
) ();

  logic [N_DEV-1:0] REQ;            // active-low requests, one per device
  logic [N_DEV-1:0] GNT;            // active-low grants, one-hot-low or all-high
  logic             FRAME;          // shared active-low FRAME
  logic             IRDY;           // shared active-low IRDY
  logic [2:0]       gnt_idx;        // current or last granted device
  logic             bus_busy;       // high while a transaction is running
  logic             timeout_pulse;  // one-cycle pulse on grant revocation

  modport master (
    input  REQ, FRAME, IRDY,
    output GNT, gnt_idx, bus_busy, timeout_pulse
  );

  modport slave (
    output REQ, FRAME, IRDY,
    input  GNT, gnt_idx, bus_busy, timeout_pulse
  );

endinterface

// File: rtl/pci_bus_arbiter.sv
// Central round-robin PCI arbiter.
// Grants the shared bus to one device at a time, revokes grants that are not
// used within GNT_TIMEOUT cycles, and inserts one turnaround cycle between
// masters. Optional bus parking on the last master is enabled by defining
// PCI_ARB_PARK_EN; without it GNT stays all high while nobody requests.
module pci_bus_arbiter #(
  parameter int N_DEV       = 3,
  parameter int GNT_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pci_bus_arbiter_if.master     bus
);

  typedef enum logic [1:0] {
    IDLE,
    GRANTED,
    BUSY,
    TURNAROUND
  } state_e;

  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(GNT_TIMEOUT - 1);
  localparam logic [2:0]       LAST_RST   = 3'(N_DEV - 1);
  localparam logic [N_DEV-1:0] GNT_NONE   = '1;

  state_e             state_q, state_d;
  logic [N_DEV-1:0]   gnt_q, gnt_d;
  logic [2:0]         gnt_idx_q, gnt_idx_d;
  logic [2:0]         last_q, last_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic               timeout_q, timeout_d;
  logic               bus_busy_q;

  logic [7:0]         req_ext;
  logic [3:0]         cand;
  logic [2:0]         winner;
  logic               any_req;
  logic               bus_idle;
  logic               do_grant;

  // Active-low grant vector with only bit idx low.
  function automatic logic [N_DEV-1:0] gnt_for(input logic [2:0] idx);
    logic [7:0] v;
    v      = '1;
    v[idx] = 1'b0;
    return v[N_DEV-1:0];
  endfunction

  assign bus_idle = bus.FRAME & bus.IRDY;

  // Pad the request vector to 8 bits so a 3-bit index is always in range.
  always_comb begin
    req_ext            = '1;
    req_ext[N_DEV-1:0] = bus.REQ;
  end

  // Round-robin search starting just after the last winner.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // a variable unassigned, which would infer a latch.
    winner  = last_q;
    any_req = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N_DEV; i++) begin
      cand = {1'b0, last_q} + 4'(i);
      if (cand >= 4'(N_DEV)) cand = cand - 4'(N_DEV);
      if (!any_req && !req_ext[cand[2:0]]) begin
        winner  = cand[2:0];
        any_req = 1'b1;
      end
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    gnt_d     = GNT_NONE;
    gnt_idx_d = gnt_idx_q;
    last_d    = last_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    do_grant  = 1'b0;

    unique case (state_q)
      IDLE: begin
`ifdef PCI_ARB_PARK_EN
        if (gnt_q != GNT_NONE) begin
          // Currently parked on last_q.
          if (!bus.FRAME) begin
            state_d = BUSY;
          end else if (any_req && (winner != last_q)) begin
            // Drop the park grant for one cycle before handing over.
            gnt_d = GNT_NONE;
          end else if (any_req && bus_idle) begin
            do_grant = 1'b1;
          end else begin
            gnt_d = gnt_q;
          end
        end else if (bus_idle && any_req) begin
          do_grant = 1'b1;
        end else if (bus_idle) begin
          gnt_d     = gnt_for(last_q);
          gnt_idx_d = last_q;
        end
`else
        if (bus_idle && any_req) do_grant = 1'b1;
`endif
      end

      GRANTED: begin
        // FRAME wins over withdrawal and timeout in the same cycle.
        if (!bus.FRAME) begin
          state_d = BUSY;
        end else if (req_ext[gnt_idx_q]) begin
          state_d = IDLE;
        end else if (timer_q == TIMER_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          gnt_d   = gnt_q;
          timer_d = timer_q + 1'b1;
        end
      end

      BUSY: begin
        if (bus_idle) state_d = TURNAROUND;
      end

      TURNAROUND: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (do_grant) begin
      state_d   = GRANTED;
      gnt_d     = gnt_for(winner);
      gnt_idx_d = winner;
      last_d    = winner;
      timer_d   = '0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before this edge, independent of statement order.
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= GNT_NONE;
      gnt_idx_q  <= '0;
      last_q     <= LAST_RST;
      timer_q    <= '0;
      timeout_q  <= 1'b0;
      bus_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      last_q     <= last_d;
      timer_q    <= timer_d;
      timeout_q  <= timeout_d;
      bus_busy_q <= (state_d == BUSY);
    end
  end

  assign bus.GNT           = gnt_q;
  assign bus.gnt_idx       = gnt_idx_q;
  assign bus.bus_busy      = bus_busy_q;
  assign bus.timeout_pulse = timeout_q;

endmodule
